// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline, the arbiter and the memory.
// The arbiter takes the slave side; the pipeline and memory drive the master side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_ready, if_rdata,
        output d_ready, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_ready, if_rdata,
        input  d_ready, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// Data side wins ties; each access is IDLE -> ACCESS(MEM_LAT) -> DONE.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                stall_pipe
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              owner;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    // Grant, wait out the memory latency, then hand data back to the owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            owner     <= OWN_IF;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            if_rdata  <= '0;
            d_ready   <= 1'b0;
            d_rdata   <= '0;
        end else begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.d_req) begin
                        mem_en    <= 1'b1;
                        mem_we    <= bus.d_we;
                        mem_addr  <= bus.d_addr;
                        mem_wdata <= bus.d_wdata;
                        cnt       <= CNT_INIT;
                        owner     <= OWN_D;
                        state     <= S_ACCESS;
                    end else if (bus.if_req) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= bus.if_addr;
                        cnt       <= CNT_INIT;
                        owner     <= OWN_IF;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_DONE;
                        if (owner == OWN_D) begin
                            d_ready <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= bus.mem_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= bus.mem_rdata;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.if_ready  = if_ready;
    assign bus.if_rdata  = if_rdata;
    assign bus.d_ready   = d_ready;
    assign bus.d_rdata   = d_rdata;

    // Freeze the pipeline while a request is pending; release on its ready cycle.
    always_comb begin
        stall_pipe = reset &
                     ((bus.if_req & ~if_ready) | (bus.d_req & ~d_ready));
    end
endmodule
